// File: rtl/tracking_pkg.sv
// rtl/tracking_pkg.sv - shared constants, types and distance helper for the target scheduler
// Purpose : zone count, screen centre, FSM/mode enums, zone record and Manhattan distance.
// Ports   : none (package).
package tracking_pkg;

    localparam int N_ZONE   = 16;
    localparam int CENTER_X = 320;
    localparam int CENTER_Y = 240;

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_SCAN       = 2'd1,
        ST_UPDATE     = 2'd2
    } fsm_state_t;

    typedef enum logic {
        MODE_SEARCH = 1'b0,
        MODE_LOCKED = 1'b1
    } track_mode_t;

    typedef struct packed {
        logic        found;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] box_x_min;
        logic [11:0] box_x_max;
        logic [11:0] box_y_min;
        logic [11:0] box_y_max;
    } zone_t;

    // Two 10-bit absolute differences summed into 11 bits cannot overflow.
    function automatic logic [10:0] manhattan(input logic [9:0] ax, input logic [9:0] ay,
                                              input logic [9:0] bx, input logic [9:0] by);
        logic [9:0] dx;
        logic [9:0] dy;
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy = (ay >= by) ? (ay - by) : (by - ay);
        return {1'b0, dx} + {1'b0, dy};
    endfunction

endpackage

// File: rtl/target_scheduler_if.sv
// rtl/target_scheduler_if.sv - detector zone-result bus into the target scheduler
// Purpose : groups the per-zone detector result strobe and fields.
// Ports   : master = detector (drives), slave = scheduler (receives).
interface target_scheduler_if;

    logic        det_valid;
    logic [3:0]  det_idx;
    logic        det_found;
    logic [9:0]  det_x;
    logic [9:0]  det_y;
    logic [11:0] det_box_x_min;
    logic [11:0] det_box_x_max;
    logic [11:0] det_box_y_min;
    logic [11:0] det_box_y_max;

    modport master (
        output det_valid, det_idx, det_found, det_x, det_y,
               det_box_x_min, det_box_x_max, det_box_y_min, det_box_y_max
    );

    modport slave (
        input  det_valid, det_idx, det_found, det_x, det_y,
               det_box_x_min, det_box_x_max, det_box_y_min, det_box_y_max
    );

endinterface

// File: rtl/zone_bank.sv
// rtl/zone_bank.sv - shadow/display double buffer of zone results
// Purpose : detector writes land in the shadow bank; swap copies shadow to display in one
//           cycle and clears shadow found bits. A write in the swap cycle lands after the clear.
// Ports   : clk, reset_n (async active-low); wr_en/wr_idx/wr_data shadow write;
//           swap copy strobe; disp registered display bank.
module zone_bank
    import tracking_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [3:0]              wr_idx,
    input  zone_t                   wr_data,
    input  logic                    swap,
    output zone_t [N_ZONE-1:0]      disp
);

    zone_t [N_ZONE-1:0] shadow_q;
    zone_t [N_ZONE-1:0] shadow_d;
    zone_t [N_ZONE-1:0] disp_q;
    zone_t [N_ZONE-1:0] disp_d;

    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        if (swap) begin
            disp_d = shadow_q;
            for (int i = 0; i < N_ZONE; i++) begin
                shadow_d[i].found = 1'b0;
            end
        end
        // Applied after the clear so a coincident write survives into the next frame.
        if (wr_en) begin
            shadow_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            disp_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
        end
    end

    assign disp = disp_q;

endmodule

// File: rtl/target_scheduler.sv
// rtl/target_scheduler.sv - per-frame zone scan and single-target tracker
// Purpose : double-buffers detector zone results, scans the display bank once per frame for
//           the candidate nearest the reference point, and maintains a locked track.
// Ports   : clk, reset_n (async active-low); frame_tick end-of-frame pulse; det detector bus;
//           target_off disables tracking; *_all display bank; trk_* selected target;
//           trk_update refresh pulse; overrun dropped-tick pulse.
module target_scheduler
    import tracking_pkg::*;
#(
    parameter int MISS_LIMIT = 8,
    parameter int JUMP_MAX   = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     frame_tick,
    target_scheduler_if.slave        det,
    input  logic                     target_off,
    output logic [N_ZONE-1:0][9:0]   aim_x_all,
    output logic [N_ZONE-1:0][9:0]   aim_y_all,
    output logic [N_ZONE-1:0]        aim_detected_all,
    output logic [N_ZONE-1:0][11:0]  box_x_min_all,
    output logic [N_ZONE-1:0][11:0]  box_x_max_all,
    output logic [N_ZONE-1:0][11:0]  box_y_min_all,
    output logic [N_ZONE-1:0][11:0]  box_y_max_all,
    output logic [9:0]               trk_x,
    output logic [9:0]               trk_y,
    output logic [3:0]               trk_idx,
    output logic                     trk_valid,
    output logic                     trk_update,
    output logic                     overrun
);

    localparam int                MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_LIMIT);
    localparam logic [10:0]       JUMP_LIM = 11'(JUMP_MAX);
    localparam logic [9:0]        CX       = 10'(CENTER_X);
    localparam logic [9:0]        CY       = 10'(CENTER_Y);
    localparam logic [3:0]        LAST_IDX = 4'(N_ZONE - 1);

    fsm_state_t         state_q, state_d;
    track_mode_t        mode_q, mode_d;
    logic [3:0]         scan_idx_q, scan_idx_d;
    logic [3:0]         best_idx_q, best_idx_d;
    logic [10:0]        best_dist_q, best_dist_d;
    logic               best_found_q, best_found_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [9:0]         trk_x_q, trk_x_d;
    logic [9:0]         trk_y_q, trk_y_d;
    logic [3:0]         trk_idx_q, trk_idx_d;
    logic               trk_valid_q, trk_valid_d;
    logic               trk_update_q, trk_update_d;
    logic               overrun_q, overrun_d;

    logic               swap;
    zone_t              wr_data;
    zone_t [N_ZONE-1:0] disp_bank;
    logic [9:0]         ref_x;
    logic [9:0]         ref_y;
    logic [10:0]        scan_dist;
    logic [MISS_W-1:0]  miss_inc;

    assign wr_data = '{found:     det.det_found,
                       x:         det.det_x,
                       y:         det.det_y,
                       box_x_min: det.det_box_x_min,
                       box_x_max: det.det_box_x_max,
                       box_y_min: det.det_box_y_min,
                       box_y_max: det.det_box_y_max};

    zone_bank u_zone_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (det.det_valid),
        .wr_idx  (det.det_idx),
        .wr_data (wr_data),
        .swap    (swap),
        .disp    (disp_bank)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        scan_idx_d   = scan_idx_q;
        best_idx_d   = best_idx_q;
        best_dist_d  = best_dist_q;
        best_found_d = best_found_q;
        miss_d       = miss_q;
        trk_x_d      = trk_x_q;
        trk_y_d      = trk_y_q;
        trk_idx_d    = trk_idx_q;
        trk_valid_d  = trk_valid_q;
        trk_update_d = 1'b0;
        overrun_d    = 1'b0;
        swap         = 1'b0;

        ref_x     = (mode_q == MODE_LOCKED) ? trk_x_q : CX;
        ref_y     = (mode_q == MODE_LOCKED) ? trk_y_q : CY;
        scan_dist = manhattan(disp_bank[scan_idx_q].x, disp_bank[scan_idx_q].y, ref_x, ref_y);
        miss_inc  = (miss_q == '1) ? miss_q : (miss_q + 1'b1);

        case (state_q)
            ST_WAIT_FRAME: begin
                if (frame_tick) begin
                    swap         = 1'b1;
                    state_d      = ST_SCAN;
                    scan_idx_d   = '0;
                    best_idx_d   = '0;
                    best_dist_d  = '1;
                    best_found_d = 1'b0;
                end
            end
            ST_SCAN: begin
                overrun_d = frame_tick;
                // Strict less-than keeps the lower zone index on ties.
                if (disp_bank[scan_idx_q].found && (!best_found_q || (scan_dist < best_dist_q))) begin
                    best_found_d = 1'b1;
                    best_idx_d   = scan_idx_q;
                    best_dist_d  = scan_dist;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = ST_UPDATE;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                overrun_d    = frame_tick;
                trk_update_d = 1'b1;
                state_d      = ST_WAIT_FRAME;
                if (target_off) begin
                    mode_d      = MODE_SEARCH;
                    trk_valid_d = 1'b0;
                    miss_d      = '0;
                end else if (mode_q == MODE_SEARCH) begin
                    if (best_found_q) begin
                        trk_x_d     = disp_bank[best_idx_q].x;
                        trk_y_d     = disp_bank[best_idx_q].y;
                        trk_idx_d   = best_idx_q;
                        trk_valid_d = 1'b1;
                        mode_d      = MODE_LOCKED;
                        miss_d      = '0;
                    end
                end else begin
                    if (best_found_q && (best_dist_q <= JUMP_LIM)) begin
                        trk_x_d   = disp_bank[best_idx_q].x;
                        trk_y_d   = disp_bank[best_idx_q].y;
                        trk_idx_d = best_idx_q;
                        miss_d    = '0;
                    end else if (miss_inc >= MISS_LIM) begin
                        mode_d      = MODE_SEARCH;
                        trk_valid_d = 1'b0;
                        miss_d      = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_FRAME;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_WAIT_FRAME;
            mode_q       <= MODE_SEARCH;
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_dist_q  <= '0;
            best_found_q <= 1'b0;
            miss_q       <= '0;
            trk_x_q      <= '0;
            trk_y_q      <= '0;
            trk_idx_q    <= '0;
            trk_valid_q  <= 1'b0;
            trk_update_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_dist_q  <= best_dist_d;
            best_found_q <= best_found_d;
            miss_q       <= miss_d;
            trk_x_q      <= trk_x_d;
            trk_y_q      <= trk_y_d;
            trk_idx_q    <= trk_idx_d;
            trk_valid_q  <= trk_valid_d;
            trk_update_q <= trk_update_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_ZONE; i++) begin
            aim_x_all[i]        = disp_bank[i].x;
            aim_y_all[i]        = disp_bank[i].y;
            aim_detected_all[i] = disp_bank[i].found;
            box_x_min_all[i]    = disp_bank[i].box_x_min;
            box_x_max_all[i]    = disp_bank[i].box_x_max;
            box_y_min_all[i]    = disp_bank[i].box_y_min;
            box_y_max_all[i]    = disp_bank[i].box_y_max;
        end
    end

    assign trk_x      = trk_x_q;
    assign trk_y      = trk_y_q;
    assign trk_idx    = trk_idx_q;
    assign trk_valid  = trk_valid_q;
    assign trk_update = trk_update_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_target_scheduler.sv
// tb/tb_target_scheduler.sv - scoreboard bench for target_scheduler
module tb_target_scheduler;
    import tracking_pkg::*;

    localparam int MISS_LIMIT = 8;
    localparam int JUMP_MAX   = 64;
    localparam int BUSY       = 18;

    typedef struct {
        bit found;
        int x, y, bx0, bx1, by0, by1;
    } mz_t;

    typedef struct {
        int due, x, y, idx;
        bit valid;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_tick = 1'b0;
    logic target_off = 1'b0;
    logic [15:0][9:0]  aim_x_all, aim_y_all;
    logic [15:0]       aim_detected_all;
    logic [15:0][11:0] box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all;
    logic [9:0]        trk_x, trk_y;
    logic [3:0]        trk_idx;
    logic              trk_valid, trk_update, overrun;

    target_scheduler_if det_if();

    target_scheduler #(.MISS_LIMIT(MISS_LIMIT), .JUMP_MAX(JUMP_MAX)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .frame_tick       (frame_tick),
        .det              (det_if),
        .target_off       (target_off),
        .aim_x_all        (aim_x_all),
        .aim_y_all        (aim_y_all),
        .aim_detected_all (aim_detected_all),
        .box_x_min_all    (box_x_min_all),
        .box_x_max_all    (box_x_max_all),
        .box_y_min_all    (box_y_min_all),
        .box_y_max_all    (box_y_max_all),
        .trk_x            (trk_x),
        .trk_y            (trk_y),
        .trk_idx          (trk_idx),
        .trk_valid        (trk_valid),
        .trk_update       (trk_update),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    mz_t  sh[16];
    mz_t  dp[16];
    bit   m_locked, m_valid;
    int   m_x, m_y, m_idx, m_miss;
    int   last_acc;
    exp_t expq[$];
    int   ovq[$];
    exp_t mon_e;
    int   mon_ov;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic mz_t mk(input bit f, input int x, input int y);
        mz_t z;
        z.found = f; z.x = x; z.y = y;
        z.bx0 = x; z.bx1 = x + 16; z.by0 = y; z.by1 = y + 16;
        return z;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            sh[i] = mk(1'b0, 0, 0);
            sh[i].bx1 = 0; sh[i].by1 = 0;
            dp[i] = sh[i];
        end
        m_locked = 0; m_valid = 0; m_x = 0; m_y = 0; m_idx = 0; m_miss = 0;
        last_acc = -1000;
        expq.delete();
        ovq.delete();
    endfunction

    // Frame decision from the display bank, evaluated at the accepted tick.
    function automatic void model_decide(input bit off, input int t);
        int rx, ry, best, bestd, d;
        exp_t e;
        rx = m_locked ? m_x : CENTER_X;
        ry = m_locked ? m_y : CENTER_Y;
        best = -1; bestd = 0;
        for (int i = 0; i < 16; i++) begin
            if (dp[i].found) begin
                d = iabs(dp[i].x - rx) + iabs(dp[i].y - ry);
                if (best < 0 || d < bestd) begin best = i; bestd = d; end
            end
        end
        if (off) begin
            m_locked = 0; m_valid = 0; m_miss = 0;
        end else if (!m_locked) begin
            if (best >= 0) begin
                m_x = dp[best].x; m_y = dp[best].y; m_idx = best;
                m_valid = 1; m_locked = 1; m_miss = 0;
            end
        end else if (best >= 0 && bestd <= JUMP_MAX) begin
            m_x = dp[best].x; m_y = dp[best].y; m_idx = best; m_miss = 0;
        end else begin
            m_miss++;
            if (m_miss >= MISS_LIMIT) begin m_locked = 0; m_valid = 0; m_miss = 0; end
        end
        e.due = t + 17; e.x = m_x; e.y = m_y; e.idx = m_idx; e.valid = m_valid;
        expq.push_back(e);
    endfunction

    function automatic void model_edge(input bit tk, input bit dv, input int idx, input mz_t z);
        if (tk) begin
            if (cyc - last_acc >= BUSY) begin
                for (int i = 0; i < 16; i++) begin dp[i] = sh[i]; sh[i].found = 0; end
                last_acc = cyc;
                model_decide(target_off, cyc);
            end else begin
                ovq.push_back(cyc);
            end
        end
        if (dv) sh[idx] = z;
    endfunction

    task automatic check_eq(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    task automatic drive(input bit tk, input bit dv, input int idx, input mz_t z);
        @(negedge clk);
        frame_tick = tk;
        det_if.det_valid = dv;
        det_if.det_idx = 4'(idx);
        det_if.det_found = z.found;
        det_if.det_x = 10'(z.x);
        det_if.det_y = 10'(z.y);
        det_if.det_box_x_min = 12'(z.bx0);
        det_if.det_box_x_max = 12'(z.bx1);
        det_if.det_box_y_min = 12'(z.by0);
        det_if.det_box_y_max = 12'(z.by1);
        @(posedge clk);
        #1;
        model_edge(tk, dv, idx, z);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, mk(1'b0, 0, 0));
    endtask

    task automatic wr(input int idx, input int x, input int y);
        drive(1'b0, 1'b1, idx, mk(1'b1, x, y));
    endtask

    task automatic tick();
        drive(1'b1, 1'b0, 0, mk(1'b0, 0, 0));
    endtask

    task automatic frame();
        tick();
        idle(19);
    endtask

    function automatic mz_t rand_zone();
        mz_t z;
        z.found = ($urandom_range(0, 7) != 0);
        if (m_valid && $urandom_range(0, 1) == 0) begin
            z.x = clampc(m_x + int'($urandom_range(0, 80)) - 40);
            z.y = clampc(m_y + int'($urandom_range(0, 80)) - 40);
        end else begin
            z.x = int'($urandom_range(0, 1023));
            z.y = int'($urandom_range(0, 1023));
        end
        z.bx0 = int'($urandom_range(0, 4095)); z.bx1 = int'($urandom_range(0, 4095));
        z.by0 = int'($urandom_range(0, 4095)); z.by1 = int'($urandom_range(0, 4095));
        return z;
    endfunction

    // Scoreboard monitor: pops expectations whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (reset_n) begin
            if (trk_update) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL trk_update unexpected at cycle %0d", cyc);
                end else begin
                    mon_e = expq.pop_front();
                    if (cyc != mon_e.due || trk_x !== 10'(mon_e.x) || trk_y !== 10'(mon_e.y) ||
                        trk_idx !== 4'(mon_e.idx) || trk_valid !== mon_e.valid) begin
                        failures++;
                        $display("FAIL trk: got cyc=%0d x=%0d y=%0d idx=%0d v=%0b want cyc=%0d x=%0d y=%0d idx=%0d v=%0b",
                                 cyc, trk_x, trk_y, trk_idx, trk_valid,
                                 mon_e.due, mon_e.x, mon_e.y, mon_e.idx, mon_e.valid);
                    end
                end
            end else if (expq.size() > 0 && cyc >= expq[0].due) begin
                checks++; failures++;
                $display("FAIL trk_update missing: got 0 want 1 at cycle %0d", expq[0].due);
                mon_e = expq.pop_front();
            end
            if (overrun) begin
                checks++;
                if (ovq.size() == 0 || ovq[0] != cyc) begin
                    failures++;
                    $display("FAIL overrun unexpected: got 1 want 0 at cycle %0d", cyc);
                end
                if (ovq.size() > 0 && ovq[0] <= cyc) mon_ov = ovq.pop_front();
            end else if (ovq.size() > 0 && cyc >= ovq[0]) begin
                checks++; failures++;
                $display("FAIL overrun missing: got 0 want 1 at cycle %0d", ovq[0]);
                mon_ov = ovq.pop_front();
            end
            checks++;
            for (int i = 0; i < 16; i++) begin
                if (aim_detected_all[i] !== dp[i].found || aim_x_all[i] !== 10'(dp[i].x) ||
                    aim_y_all[i] !== 10'(dp[i].y) || box_x_min_all[i] !== 12'(dp[i].bx0) ||
                    box_x_max_all[i] !== 12'(dp[i].bx1) || box_y_min_all[i] !== 12'(dp[i].by0) ||
                    box_y_max_all[i] !== 12'(dp[i].by1)) begin
                    failures++;
                    $display("FAIL display zone %0d cyc %0d: got f=%0b x=%0d y=%0d want f=%0b x=%0d y=%0d",
                             i, cyc, aim_detected_all[i], aim_x_all[i], aim_y_all[i],
                             dp[i].found, dp[i].x, dp[i].y);
                    break;
                end
            end
        end
    end

    initial begin
        int len, extra;
        bit tk, dv;
        model_reset();
        det_if.det_valid = 0; det_if.det_idx = 0; det_if.det_found = 0;
        det_if.det_x = 0; det_if.det_y = 0;
        det_if.det_box_x_min = 0; det_if.det_box_x_max = 0;
        det_if.det_box_y_min = 0; det_if.det_box_y_max = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        check_eq("reset trk_valid", trk_valid, 0);
        check_eq("reset trk_update", trk_update, 0);
        check_eq("reset aim_detected_all", aim_detected_all, 0);

        // Single candidate in search: latency and load.
        wr(5, 300, 250);
        tick();
        idle(16);
        check_eq("trk_update before 18", trk_update, 0);
        idle(1);
        check_eq("trk_update at 18", trk_update, 1);
        check_eq("trk_x zone5", trk_x, 300);
        check_eq("trk_y zone5", trk_y, 250);
        check_eq("trk_idx zone5", trk_idx, 5);
        check_eq("trk_valid zone5", trk_valid, 1);
        idle(2);

        // Tie at distance 30 keeps the lower zone.
        target_off = 1'b1; frame(); target_off = 1'b0;
        check_eq("target_off valid", trk_valid, 0);
        wr(9, 320, 270);
        wr(2, 350, 240);
        frame();
        check_eq("tie trk_idx", trk_idx, 2);

        // Out-of-range candidates until the track drops.
        target_off = 1'b1; frame(); target_off = 1'b0;
        wr(0, 100, 100);
        frame();
        check_eq("lock trk_x", trk_x, 100);
        for (int k = 1; k <= MISS_LIMIT; k++) begin
            wr(3, 300, 300);
            frame();
            if (k == MISS_LIMIT - 1) begin
                check_eq("held trk_valid", trk_valid, 1);
                check_eq("held trk_x", trk_x, 100);
                check_eq("held trk_idx", trk_idx, 0);
            end
        end
        check_eq("dropped trk_valid", trk_valid, 0);

        // Tick during scan is dropped; shadow write survives to the next accepted tick.
        tick();
        idle(2);
        wr(4, 500, 400);
        idle(1);
        tick();
        check_eq("overrun pulse", overrun, 1);
        check_eq("display no zone4 yet", aim_detected_all[4], 0);
        idle(16);
        frame();
        check_eq("display zone4 after swap", aim_detected_all[4], 1);
        check_eq("overrun data trk_idx", trk_idx, 4);

        // Write coincident with swap lands in the next frame.
        drive(1'b1, 1'b1, 7, mk(1'b1, 200, 200));
        check_eq("coincident absent", aim_detected_all[7], 0);
        idle(19);
        frame();
        check_eq("coincident present", aim_detected_all[7], 1);

        // Reset in the middle of a scan.
        wr(1, 330, 240);
        tick();
        idle(7);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("mid-scan reset trk_x", trk_x, 0);
        check_eq("mid-scan reset trk_y", trk_y, 0);
        check_eq("mid-scan reset trk_idx", trk_idx, 0);
        check_eq("mid-scan reset trk_valid", trk_valid, 0);
        check_eq("mid-scan reset trk_update", trk_update, 0);
        check_eq("mid-scan reset overrun", overrun, 0);
        check_eq("mid-scan reset aim_detected", aim_detected_all, 0);
        check_eq("mid-scan reset aim_x nonzero", int'(aim_x_all != '0), 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(25);

        // Randomised frames with occasional dropped ticks and target_off.
        for (int f = 0; f < 60; f++) begin
            target_off = ($urandom_range(0, 7) == 0);
            len = int'($urandom_range(BUSY, BUSY + 8));
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BUSY - 1)) : -1;
            for (int c = 0; c < len; c++) begin
                tk = (c == 0) || (c == extra);
                dv = ($urandom_range(0, 2) == 0);
                drive(tk, dv, int'($urandom_range(0, 15)), rand_zone());
            end
        end
        idle(20);
        check_eq("scoreboard trk queue drained", expq.size(), 0);
        check_eq("scoreboard overrun queue drained", ovq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/target_scheduler.md
TARGET_SCHEDULER -- requirements
Module: target_scheduler

Interface
REQ-001 SHALL have parameter MISS_LIMIT, default 8: consecutive frames without a match before a locked track drops.
REQ-002 SHALL have parameter JUMP_MAX, default 64: maximum Manhattan distance, in pixels, for a candidate to match the locked track.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports clk and reset_n.
REQ-004 clk  input  1  system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse at end of frame.
REQ-007 det_valid  input  1  detector zone-result strobe.
REQ-008 det_idx  input  4  zone number 0..15.
REQ-009 det_found, det_x[9:0], det_y[9:0], det_box_x_min/x_max/y_min/y_max[11:0]  input  zone result fields.
REQ-010 target_off  input  1  forces tracking off.
REQ-011 aim_x_all[15:0][9:0], aim_y_all[15:0][9:0], aim_detected_all[15:0], box_x_min_all..box_y_max_all[15:0][11:0]  output  display bank to the pixel mixer.
REQ-012 trk_x[9:0], trk_y[9:0], trk_idx[3:0], trk_valid  output  selected target for motor control.
REQ-013 trk_update  output  1  one-cycle pulse when trk_* are refreshed.
REQ-014 overrun  output  1  one-cycle pulse when frame_tick is dropped.

Function
REQ-015 SHALL write det_* into shadow entry det_idx on each det_valid; later writes to the same entry overwrite earlier ones.
REQ-016 On frame_tick in WAIT_FRAME, SHALL copy the shadow bank to the display bank in one cycle, clear all shadow found bits, and enter SCAN.
REQ-017 det_valid coincident with the swap SHALL land in the cleared shadow bank, so it survives for the next frame.
REQ-018 Display outputs SHALL change only at a swap; they are registered and stable between swaps.
REQ-019 Control FSM SHALL have states WAIT_FRAME -> SCAN (16 cycles, zones 0..15, one per cycle) -> UPDATE (1 cycle) -> WAIT_FRAME.
REQ-020 frame_tick outside WAIT_FRAME SHALL be dropped: no swap, shadow left intact, overrun pulsed.
REQ-021 SCAN SHALL compute, for each found zone, an 11-bit distance |x-rx|+|y-ry| with no overflow.
REQ-022 Reference point (rx,ry) SHALL be (320,240) in mode SEARCH and (trk_x,trk_y) in mode LOCKED.
REQ-023 SCAN SHALL keep the minimum distance; a tie SHALL keep the lower zone index.
REQ-024 UPDATE with target_off=1: mode SEARCH, trk_valid=0, miss counter cleared.
REQ-025 UPDATE in SEARCH with any candidate: load trk_* from the best zone, trk_valid=1, mode LOCKED, miss=0.
REQ-026 UPDATE in SEARCH with no candidate: trk_* and trk_valid unchanged.
REQ-027 UPDATE in LOCKED with best distance <= JUMP_MAX: load trk_* from the best zone, miss=0.
REQ-028 UPDATE in LOCKED with no candidate within JUMP_MAX: hold trk_*, miss+1.
REQ-029 When the miss count reaches MISS_LIMIT: mode SEARCH, trk_valid=0, miss=0.
REQ-030 Miss counter SHALL saturate and never wrap.
REQ-031 trk_update SHALL pulse the cycle after every UPDATE, 18 cycles after the frame_tick sample edge.

Reset
REQ-032 reset_n low SHALL asynchronously clear all banks, all trk_*, trk_update, overrun and the miss count, and set FSM to WAIT_FRAME, mode SEARCH.
REQ-033 Reset mid-SCAN SHALL abort with no trk_update.

Structure
REQ-034 tracking_pkg SHALL hold N_ZONE=16, CENTER_X=320, CENTER_Y=240, and the FSM and mode enums.
REQ-035 Sub-module zone_bank SHALL implement the shadow/display double buffer and swap.

Verification
REQ-036 Zone 5 found at (300,250), frame_tick -> after 18 cycles trk=(300,250), trk_idx=5, trk_valid=1, trk_update=1.
REQ-037 Zones 2 and 9 both at distance 30 from the centre -> trk_idx=2.
REQ-038 Locked at (100,100); next frame only zone at (300,300) -> trk held; after 8 such frames trk_valid=0.
REQ-039 frame_tick during SCAN -> overrun=1, display bank unchanged, shadow data used at the next accepted tick.
REQ-040 det_valid coincident with frame_tick -> entry absent from the current display bank, present after the following swap.
REQ-041 reset_n low at SCAN cycle 7 -> all outputs zero immediately, no trk_update.
